// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_stage
// Brief    : Registered RV32I/RV64I immediate generator with a valid/ready
//            handshake, stall backpressure and flush.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
    parameter int XLEN       = 32,
    parameter bit SLTIU_ZEXT = 1'b1,
    parameter int PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;

    localparam logic [2:0] c_FMT_NONE  = 3'd0;
    localparam logic [2:0] c_FMT_I     = 3'd1;
    localparam logic [2:0] c_FMT_S     = 3'd2;
    localparam logic [2:0] c_FMT_B     = 3'd3;
    localparam logic [2:0] c_FMT_U     = 3'd4;
    localparam logic [2:0] c_FMT_J     = 3'd5;
    localparam logic [2:0] c_FMT_SHAMT = 3'd6;

    localparam bit c_RV64 = (XLEN == 64);

    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_iz;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_shamt5;
    logic [XLEN-1:0] w_shamt6;
    logic [XLEN-1:0] w_shamt_op;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_in_ready;
    logic            w_load;

    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_fmt;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];

    assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_imm_iz = {{(XLEN-12){1'b0}}, in_instr[31:20]};
    assign w_imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    assign w_shamt5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign w_shamt6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};

    // RV64 widens the OP-IMM shift amount to six bits; OP-IMM-32 stays at five.
    assign w_shamt_op = c_RV64 ? w_shamt6 : w_shamt5;

    generate
        if (XLEN > 32) begin : g_u_ext
            assign w_imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
        end else begin : g_u_flat
            assign w_imm_u = {in_instr[31:12], 12'b0};
        end
    endgenerate

    always_comb begin
        w_imm = '0;
        w_fmt = c_FMT_NONE;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm = w_imm_u;
                w_fmt = c_FMT_U;
            end
            c_OP_JAL: begin
                w_imm = w_imm_j;
                w_fmt = c_FMT_J;
            end
            c_OP_JALR, c_OP_LOAD: begin
                w_imm = w_imm_i;
                w_fmt = c_FMT_I;
            end
            c_OP_IMM: begin
                case (w_funct3)
                    3'b001, 3'b101: begin
                        w_imm = w_shamt_op;
                        w_fmt = c_FMT_SHAMT;
                    end
                    3'b011: begin
                        w_imm = SLTIU_ZEXT ? w_imm_iz : w_imm_i;
                        w_fmt = c_FMT_I;
                    end
                    default: begin
                        w_imm = w_imm_i;
                        w_fmt = c_FMT_I;
                    end
                endcase
            end
            c_OP_IMM32: begin
                if (c_RV64) begin
                    case (w_funct3)
                        3'b000: begin
                            w_imm = w_imm_i;
                            w_fmt = c_FMT_I;
                        end
                        3'b001, 3'b101: begin
                            w_imm = w_shamt5;
                            w_fmt = c_FMT_SHAMT;
                        end
                        default: begin
                            w_imm = '0;
                            w_fmt = c_FMT_NONE;
                        end
                    endcase
                end
            end
            c_OP_BRANCH: begin
                w_imm = w_imm_b;
                w_fmt = c_FMT_B;
            end
            c_OP_STORE: begin
                w_imm = w_imm_s;
                w_fmt = c_FMT_S;
            end
            default: begin
                w_imm = '0;
                w_fmt = c_FMT_NONE;
            end
        endcase
    end

    assign w_in_ready = !r_valid || out_ready;
    assign w_load     = in_valid && w_in_ready && !flush;

    // Payload only moves on a load, so stalls, drains and flushes keep it stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_imm   <= '0;
            r_fmt   <= c_FMT_NONE;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_imm   <= w_imm;
            r_fmt   <= w_fmt;
            r_instr <= in_instr;
            r_pc    <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_imm   = r_imm;
    assign out_fmt   = r_fmt;
    assign out_instr = r_instr;
    assign out_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_stage
// Brief    : Bench for imm_gen_stage in three configurations sharing stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        a_rdy, a_v, b_rdy, b_v, c_rdy, c_v;
    logic [31:0] a_imm, b_imm;
    logic [63:0] c_imm;
    logic [2:0]  a_fmt, b_fmt, c_fmt;
    logic [31:0] a_ins, b_ins, c_ins, a_pc, b_pc, c_pc;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .SLTIU_ZEXT(1'b1), .PC_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_v), .out_ready(out_ready),
        .out_imm(a_imm), .out_fmt(a_fmt), .out_instr(a_ins), .out_pc(a_pc));

    imm_gen_stage #(.XLEN(32), .SLTIU_ZEXT(1'b0), .PC_W(32)) dut32s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_v), .out_ready(out_ready),
        .out_imm(b_imm), .out_fmt(b_fmt), .out_instr(b_ins), .out_pc(b_pc));

    imm_gen_stage #(.XLEN(64), .SLTIU_ZEXT(1'b1), .PC_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_v), .out_ready(out_ready),
        .out_imm(c_imm), .out_fmt(c_fmt), .out_instr(c_ins), .out_pc(c_pc));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic longint sx(input longint x, input int n);
        return (x >= (longint'(1) << (n - 1))) ? x - (longint'(1) << n) : x;
    endfunction

    // Returns {fmt, imm} with imm reduced to the configured width.
    function automatic logic [66:0] mdecode(input logic [31:0] ins, input int xlen, input bit zext);
        longint v;
        logic [2:0] f;
        logic [63:0] r;
        v = 0;
        f = 3'd0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                f = 3'd4;
                v = sx(longint'(ins[31:12]) * 4096, 32);
            end
            7'h6F: begin
                f = 3'd5;
                v = sx(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096
                       + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            end
            7'h67, 7'h03: begin
                f = 3'd1;
                v = sx(longint'(ins[31:20]), 12);
            end
            7'h13: begin
                if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
                    f = 3'd6;
                    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    f = 3'd1;
                    v = (ins[14:12] == 3'd3 && zext) ? longint'(ins[31:20])
                                                     : sx(longint'(ins[31:20]), 12);
                end
            end
            7'h1B: begin
                if (xlen == 64 && ins[14:12] == 3'd0) begin
                    f = 3'd1;
                    v = sx(longint'(ins[31:20]), 12);
                end else if (xlen == 64 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) begin
                    f = 3'd6;
                    v = longint'(ins[24:20]);
                end
            end
            7'h63: begin
                f = 3'd3;
                v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                       + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            end
            7'h23: begin
                f = 3'd2;
                v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            end
            default: begin
                f = 3'd0;
                v = 0;
            end
        endcase
        r = 64'(v);
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return {f, r};
    endfunction

    int          cx[3] = '{32, 32, 64};
    bit          cz[3] = '{1'b1, 1'b0, 1'b1};
    logic        mv;
    logic [31:0] minstr, mpc;
    logic [66:0] mdec[3];

    always @(posedge clk) begin
        if (rst) begin
            mv     <= 1'b0;
            minstr <= '0;
            mpc    <= '0;
            for (int k = 0; k < 3; k++) mdec[k] <= '0;
        end else if (flush) begin
            mv <= 1'b0;
        end else if (in_valid && (!mv || out_ready)) begin
            mv     <= 1'b1;
            minstr <= in_instr;
            mpc    <= in_pc;
            for (int k = 0; k < 3; k++) mdec[k] <= mdecode(in_instr, cx[k], cz[k]);
        end else if (out_ready) begin
            mv <= 1'b0;
        end
    end

    task automatic cmp_cfg(input string tag, input int k, input logic rdy, input logic v,
                           input logic [63:0] imm, input logic [2:0] fmt,
                           input logic [31:0] ins, input logic [31:0] pc);
        check({tag, ".in_ready"}, {63'b0, rdy}, {63'b0, (!mv || out_ready)});
        check({tag, ".out_valid"}, {63'b0, v}, {63'b0, mv});
        check({tag, ".out_imm"}, imm, mdec[k][63:0]);
        check({tag, ".out_fmt"}, {61'b0, fmt}, {61'b0, mdec[k][66:64]});
        check({tag, ".out_instr"}, {32'b0, ins}, {32'b0, minstr});
        check({tag, ".out_pc"}, {32'b0, pc}, {32'b0, mpc});
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_cfg("x32z", 0, a_rdy, a_v, {32'b0, a_imm}, a_fmt, a_ins, a_pc);
            cmp_cfg("x32s", 1, b_rdy, b_v, {32'b0, b_imm}, b_fmt, b_ins, b_pc);
            cmp_cfg("x64",  2, c_rdy, c_v, c_imm, c_fmt, c_ins, c_pc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = in_pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[10];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h63, 7'h23, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        in_pc = 32'h0000_1000;
        step();
        started = 1'b1;
        step();
        check("reset.valid", {63'b0, a_v}, 64'd0);
        check("reset.imm", {32'b0, a_imm}, 64'd0);
        check("reset.in_ready", {63'b0, a_rdy}, 64'd1);

        rst = 1'b0;
        out_ready = 1'b1;
        put(32'hFFF00093);
        step();
        check("addi.valid", {63'b0, a_v}, 64'd1);
        check("addi.imm32", {32'b0, a_imm}, 64'h0000_0000_FFFF_FFFF);
        check("addi.fmt", {61'b0, a_fmt}, 64'd1);
        check("addi.imm64", c_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        put(32'hFFF03093);
        step();
        check("sltiu.zext", {32'b0, a_imm}, 64'h0000_0000_0000_0FFF);
        check("sltiu.sext", {32'b0, b_imm}, 64'h0000_0000_FFFF_FFFF);

        put(32'h41F05093);
        step();
        check("srai.imm", {32'b0, a_imm}, 64'h1F);
        check("srai.fmt", {61'b0, a_fmt}, 64'd6);

        put(32'hFE000EE3);
        step();
        check("beq.imm", {32'b0, a_imm}, 64'h0000_0000_FFFF_FFFC);
        check("beq.fmt", {61'b0, a_fmt}, 64'd3);

        out_ready = 1'b0;
        put(32'h00100093);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.in_ready", {63'b0, a_rdy}, 64'd0);
            check("stall.imm", {32'b0, a_imm}, 64'h0000_0000_FFFF_FFFC);
            check("stall.instr", {32'b0, a_ins}, 64'h0000_0000_FE00_0EE3);
        end
        flush = 1'b1;
        step();
        check("flush.valid", {63'b0, a_v}, 64'd0);
        check("flush.instr", {32'b0, a_ins}, 64'h0000_0000_FE00_0EE3);
        flush = 1'b0;
        out_ready = 1'b1;

        put(32'h03F01093);
        step();
        check("slli64.imm", c_imm, 64'h3F);
        put(32'h800000B7);
        step();
        check("lui64.imm", c_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui64.fmt", {61'b0, c_fmt}, 64'd4);
        put(32'h0000001B);
        step();
        check("addiw.fmt", {61'b0, c_fmt}, 64'd1);
        check("addiw.imm", c_imm, 64'd0);
        check("opimm32.fmt32", {61'b0, a_fmt}, 64'd0);

        put(32'h00500093);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rststall.valid", {63'b0, a_v}, 64'd0);
        check("rststall.imm", {32'b0, a_imm}, 64'd0);
        check("rststall.in_ready", {63'b0, a_rdy}, 64'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        put(32'h0000007F);
        step();
        check("unknown.valid", {63'b0, a_v}, 64'd1);
        check("unknown.imm", {32'b0, a_imm}, 64'd0);
        check("unknown.fmt", {61'b0, a_fmt}, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            step();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage for the decode path of the pipeline. It accepts one instruction per cycle on a valid/ready handshake, decodes its immediate for RV32I or RV64I, and presents the immediate, its format code and the passed-through instruction/PC from a single output register. It supports stall backpressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; any other value is a fatal elaboration error.
SLTIU_ZEXT, 1, 1 = SLTIU immediate zero-extended (current core behaviour); 0 = sign-extended per ISA.
PC_W, 32, width of the PC sideband.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  kill the held entry and any entry accepted in the same cycle.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept this cycle.
in_instr  in  32  instruction word.
in_pc  in  PC_W  instruction PC.
out_valid  out  1  output register holds a live entry.
out_ready  in  1  downstream accepts.
out_imm  out  XLEN  decoded immediate.
out_fmt  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
out_instr  out  32  registered instruction.
out_pc  out  PC_W  registered PC.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0; out_imm, out_fmt, out_instr, out_pc = 0. Reset overrides flush and load, including mid-stall.
- in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
- Load: in_valid && in_ready && !flush -> next edge: out_valid=1, out_* = decode(in_instr), in_pc. Latency is 1 cycle.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0. Payload registers hold their last value.
- Stall: out_valid && !out_ready -> all out_* are held bit-stable and in_ready=0.
- Flush (no rst): out_valid=0 at the next edge. A simultaneous input is dropped, not loaded. Payload registers are unchanged.
- Decode; sign extension is always to XLEN from the top immediate bit:
  - LUI 0110111, AUIPC 0010111: U; {instr[31:12],12'b0} sign-extended from bit 31 (relevant when XLEN=64).
  - JAL 1101111: J; {instr[31],instr[19:12],instr[20],instr[30:21],0}, sign-extended.
  - JALR 1100111, LOAD 0000011: I; instr[31:20], sign-extended.
  - OP-IMM 0010011:
    - funct3 000/010/100/110/111: I, sign-extended.
    - funct3 011 (SLTIU): I; zero-extended if SLTIU_ZEXT=1, else sign-extended.
    - funct3 001/101: SHAMT, zero-extended. The field is instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64. funct7 bits are ignored.
  - OP-IMM-32 0011011, only when XLEN=64:
    - funct3 000: I, sign-extended.
    - funct3 001/101: SHAMT, instr[24:20] zero-extended.
    - Other funct3: none.
    - When XLEN=32 this opcode decodes as none.
  - BRANCH 1100011: B; {instr[31],instr[7],instr[30:25],instr[11:8],0}, sign-extended.
  - STORE 0100011: S; {instr[31:25],instr[11:7]}, sign-extended.
  - Any other opcode: imm=0, fmt=0. The entry is still passed through with out_valid=1.
- Throughput: one instruction per cycle when out_ready is held high.

Test Plan:
- XLEN=32, load 0xFFF00093 (addi -1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
- Load 0xFFF03093 (sltiu): SLTIU_ZEXT=1 -> out_imm=0x00000FFF. SLTIU_ZEXT=0 -> out_imm=0xFFFFFFFF.
- Back-to-back loads of 0x41F05093 (srai 31) and 0xFE000EE3 (beq -4) -> out_imm=0x1F, fmt=6; then out_imm=0xFFFFFFFC, fmt=3, on consecutive cycles.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* bit-stable. Then flush=1 with in_valid=1 -> out_valid=0 next cycle, and the input is not captured.
- XLEN=64: load 0x03F01093 (slli 63) -> out_imm=0x3F. Load 0x800000B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000. Load 0x0000001B (opcode 0011011, funct3 000) -> fmt=1, imm=0.
- Assert rst during a stall with out_valid=1 -> next cycle out_valid=0, out_imm=0, in_ready=1. Unknown opcode 0x0000007F -> out_valid=1, imm=0, fmt=0.
